// File: rtl/rs_simple.sv
// ============================================================================
// Module   : rs_simple
// Purpose  : Age-ordered collapsing reservation station for the simple FU,
//            with operand capture from two writeback broadcasts.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module rs_simple #(
  parameter int DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        dispatch_0_valid,
  input  logic [80:0] dispatch_0_inst,
  input  logic [3:0]  dispatch_0_rob,
  input  logic        dispatch_1_valid,
  input  logic [80:0] dispatch_1_inst,
  input  logic [3:0]  dispatch_1_rob,
  input  logic        wb_0_valid,
  input  logic [3:0]  wb_0_rob,
  input  logic [31:0] wb_0_data,
  input  logic        wb_1_valid,
  input  logic [3:0]  wb_1_rob,
  input  logic [31:0] wb_1_data,
  input  logic        simple_0_issue,
  input  logic        simple_1_issue,
  output logic [80:0] rs_simple_0,
  output logic [80:0] rs_simple_1,
  output logic [3:0]  rs_simple_0_entry_num,
  output logic [3:0]  rs_simple_1_entry_num,
  output logic        selector,
  output logic        rs_full,
  output logic [3:0]  rs_count
);

  localparam int IW = $clog2(DEPTH);

  logic [80:0] ent_q [DEPTH];
  logic [80:0] ent_d [DEPTH];
  logic [3:0]  rob_q [DEPTH];
  logic [3:0]  rob_d [DEPTH];
  logic [3:0]  count_q;
  logic [3:0]  count_d;
  logic [3:0]  surv_w;
  logic [3:0]  tail1_w;
  logic        rm0_w;
  logic        rm1_w;
  logic        take0_w;
  logic        take1_w;
  logic        full_w;

  // Operand capture; broadcast 0 has priority over broadcast 1.
  function automatic logic [80:0] wake(
    input logic [80:0] e,
    input logic        v0,
    input logic [3:0]  r0,
    input logic [31:0] d0,
    input logic        v1,
    input logic [3:0]  r1,
    input logic [31:0] d1
  );
    logic [80:0] w;
    w = e;
    if (!e[5]) begin
      if (v0 && (r0 == e[9:6])) begin
        w[37:6] = d0;
        w[5]    = 1'b1;
      end else if (v1 && (r1 == e[9:6])) begin
        w[37:6] = d1;
        w[5]    = 1'b1;
      end
    end
    if (!e[38]) begin
      if (v0 && (r0 == e[42:39])) begin
        w[70:39] = d0;
        w[38]    = 1'b1;
      end else if (v1 && (r1 == e[42:39])) begin
        w[70:39] = d1;
        w[38]    = 1'b1;
      end
    end
    return w;
  endfunction

  assign full_w  = (count_q > 4'(DEPTH - 2));
  assign rm0_w   = simple_0_issue && (count_q != 4'd0);
  assign rm1_w   = simple_1_issue && (count_q > 4'd1);
  assign take0_w = dispatch_0_valid && !full_w;
  assign take1_w = dispatch_1_valid && !full_w;
  assign surv_w  = count_q - {3'd0, rm0_w} - {3'd0, rm1_w};
  assign tail1_w = surv_w + {3'd0, take0_w};
  assign count_d = surv_w + {3'd0, take0_w} + {3'd0, take1_w};

  for (genvar j = 0; j < DEPTH; j++) begin : g_slot
    logic [3:0]  src_w;
    logic [80:0] sh_inst_w;
    logic [3:0]  sh_rob_w;
    logic [80:0] pre_inst_w;
    logic [3:0]  pre_rob_w;

    // Survivor that collapses into this slot after the removals.
    assign src_w = 4'(j) + {3'd0, rm0_w} + {3'd0, rm1_w && (rm0_w || (j != 0))};
    assign sh_inst_w = (src_w < 4'(DEPTH)) ? ent_q[src_w[IW-1:0]] : '0;
    assign sh_rob_w  = (src_w < 4'(DEPTH)) ? rob_q[src_w[IW-1:0]] : '0;

    always_comb begin
      pre_inst_w = sh_inst_w;
      pre_rob_w  = sh_rob_w;
      if (take0_w && (4'(j) == surv_w)) begin
        pre_inst_w = dispatch_0_inst;
        pre_rob_w  = dispatch_0_rob;
      end else if (take1_w && (4'(j) == tail1_w)) begin
        pre_inst_w = dispatch_1_inst;
        pre_rob_w  = dispatch_1_rob;
      end
    end

    assign ent_d[j] = (4'(j) < count_d)
                    ? wake(pre_inst_w, wb_0_valid, wb_0_rob, wb_0_data,
                           wb_1_valid, wb_1_rob, wb_1_data)
                    : '0;
    assign rob_d[j] = (4'(j) < count_d) ? pre_rob_w : '0;
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      count_q <= 4'd0;
      for (int i = 0; i < DEPTH; i++) begin
        ent_q[i] <= '0;
        rob_q[i] <= '0;
      end
    end else begin
      count_q <= count_d;
      for (int i = 0; i < DEPTH; i++) begin
        ent_q[i] <= ent_d[i];
        rob_q[i] <= rob_d[i];
      end
    end
  end

  assign rs_simple_0           = (count_q != 4'd0) ? ent_q[0] : '0;
  assign rs_simple_1           = (count_q > 4'd1)  ? ent_q[1] : '0;
  assign rs_simple_0_entry_num = (count_q != 4'd0) ? rob_q[0] : '0;
  assign rs_simple_1_entry_num = (count_q > 4'd1)  ? rob_q[1] : '0;
  assign selector              = 1'b1;
  assign rs_full               = full_w;
  assign rs_count              = count_q;

endmodule

`default_nettype wire

// File: tb/tb_rs_simple.sv
// ============================================================================
// Module   : tb_rs_simple
// Purpose  : Directed and random checks of rs_simple against a queue model.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_rs_simple;

  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst, flush;
  logic        d0v, d1v, wb0v, wb1v, is0, is1;
  logic [80:0] d0i, d1i;
  logic [3:0]  d0r, d1r, wb0r, wb1r;
  logic [31:0] wb0d, wb1d;
  logic [80:0] o0, o1;
  logic [3:0]  n0, n1, cnt;
  logic        sel, full;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct packed {
    logic [80:0] inst;
    logic [3:0]  rob;
  } ent_t;
  ent_t mq[$];

  always #5 clk = ~clk;

  rs_simple #(.DEPTH(DEPTH)) u_dut (
    .clk(clk), .rst(rst), .flush(flush),
    .dispatch_0_valid(d0v), .dispatch_0_inst(d0i), .dispatch_0_rob(d0r),
    .dispatch_1_valid(d1v), .dispatch_1_inst(d1i), .dispatch_1_rob(d1r),
    .wb_0_valid(wb0v), .wb_0_rob(wb0r), .wb_0_data(wb0d),
    .wb_1_valid(wb1v), .wb_1_rob(wb1r), .wb_1_data(wb1d),
    .simple_0_issue(is0), .simple_1_issue(is1),
    .rs_simple_0(o0), .rs_simple_1(o1),
    .rs_simple_0_entry_num(n0), .rs_simple_1_entry_num(n1),
    .selector(sel), .rs_full(full), .rs_count(cnt)
  );

  task automatic chk(input string tag, input logic [80:0] got, input logic [80:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [80:0] mk(input logic [31:0] s2, input logic s2v,
                                     input logic [31:0] s1, input logic s1v,
                                     input logic [4:0] rd);
    return {5'h0b, 5'b00010, s2, s2v, s1, s1v, rd};
  endfunction

  function automatic logic [80:0] rand_inst();
    logic [31:0] s1, s2;
    logic        v1, v2;
    s1 = $urandom; s2 = $urandom;
    v1 = 1'($urandom_range(0, 1)); v2 = 1'($urandom_range(0, 1));
    if (!v1) s1[3:0] = 4'($urandom_range(0, 7));
    if (!v2) s2[3:0] = 4'($urandom_range(0, 7));
    return {5'($urandom), 5'($urandom), s2, v2, s1, v1, 5'($urandom)};
  endfunction

  // Operand capture as described for a waiting source; broadcast 0 first.
  function automatic logic [80:0] mwake(input logic [80:0] e);
    logic [31:0] s1, s2;
    logic        v1, v2;
    s1 = e[37:6]; v1 = e[5]; s2 = e[70:39]; v2 = e[38];
    if (!v1 && wb0v && wb0r == s1[3:0])      begin s1 = wb0d; v1 = 1'b1; end
    else if (!v1 && wb1v && wb1r == s1[3:0]) begin s1 = wb1d; v1 = 1'b1; end
    if (!v2 && wb0v && wb0r == s2[3:0])      begin s2 = wb0d; v2 = 1'b1; end
    else if (!v2 && wb1v && wb1r == s2[3:0]) begin s2 = wb1d; v2 = 1'b1; end
    return {e[80:71], s2, v2, s1, v1, e[4:0]};
  endfunction

  task automatic model_step();
    bit was_full;
    if (rst || flush) begin
      mq.delete();
      return;
    end
    was_full = (mq.size() > DEPTH - 2);
    if (is1 && mq.size() > 1) mq.delete(1);
    if (is0 && mq.size() > 0) mq.delete(0);
    if (!was_full) begin
      if (d0v) mq.push_back('{inst: d0i, rob: d0r});
      if (d1v) mq.push_back('{inst: d1i, rob: d1r});
    end
    foreach (mq[k]) mq[k].inst = mwake(mq[k].inst);
  endtask

  task automatic compare_all();
    chk("rs0",   o0,  mq.size() > 0 ? mq[0].inst : 81'd0);
    chk("rs1",   o1,  mq.size() > 1 ? mq[1].inst : 81'd0);
    chk("num0",  81'(n0), 81'(mq.size() > 0 ? mq[0].rob : 4'd0));
    chk("num1",  81'(n1), 81'(mq.size() > 1 ? mq[1].rob : 4'd0));
    chk("count", 81'(cnt), 81'(mq.size()));
    chk("full",  81'(full), 81'(mq.size() > DEPTH - 2));
    chk("sel",   81'(sel), 81'd1);
  endtask

  task automatic step();
    model_step();
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic idle();
    rst = 0; flush = 0; d0v = 0; d1v = 0; wb0v = 0; wb1v = 0; is0 = 0; is1 = 0;
    d0i = '0; d1i = '0; d0r = '0; d1r = '0; wb0r = '0; wb1r = '0; wb0d = '0; wb1d = '0;
  endtask

  initial begin
    idle();
    rst = 1;
    step(); step();
    chk("reset_count", 81'(cnt), 81'd0);
    chk("reset_rs0", o0, 81'd0);

    // Basic dispatch presentation
    idle(); d0v = 1; d0i = mk(32'h11, 1, 32'h22, 1, 5'd7); d0r = 4'd3;
    step();
    chk("t1_inst", o0, mk(32'h11, 1, 32'h22, 1, 5'd7));
    chk("t1_num", 81'(n0), 81'd3);
    chk("t1_cnt", 81'(cnt), 81'd1);
    idle(); flush = 1; step();

    // Later wakeup of s1
    idle(); d0v = 1; d0i = mk(32'h5, 1, 32'h5, 0, 5'd1); d0r = 4'd2;
    step(); idle(); step();
    wb0v = 1; wb0r = 4'd5; wb0d = 32'hDEADBEEF;
    step();
    chk("t2_s1", 81'(o0[37:6]), 81'h0DEADBEEF);
    chk("t2_s1v", 81'(o0[5]), 81'd1);
    idle(); flush = 1; step();

    // Wakeup in the dispatch cycle
    idle(); d0v = 1; d0i = mk(32'h7, 0, 32'h9, 1, 5'd2); d0r = 4'd4;
    wb1v = 1; wb1r = 4'd7; wb1d = 32'h12;
    step();
    chk("t3_s2", 81'(o0[70:39]), 81'h12);
    chk("t3_s2v", 81'(o0[38]), 81'd1);
    idle(); flush = 1; step();

    // Fill with robs 0..7 then remove slot 1
    for (int k = 0; k < DEPTH; k += 2) begin
      idle(); d0v = 1; d1v = 1;
      d0i = mk(32'(k), 1, 32'(k), 1, 5'(k)); d0r = 4'(k);
      d1i = mk(32'(k + 1), 1, 32'(k + 1), 1, 5'(k + 1)); d1r = 4'(k + 1);
      step();
    end
    chk("t4_full", 81'(full), 81'd1);
    idle(); is1 = 1; step();
    chk("t4_num1", 81'(n1), 81'd2);
    chk("t4_cnt", 81'(cnt), 81'd7);
    chk("t4_full7", 81'(full), 81'd1);

    // Both issues and both dispatches at count 6
    idle(); is0 = 1; step();
    idle(); is0 = 1; is1 = 1; d0v = 1; d1v = 1;
    d0i = mk(32'hA, 1, 32'hA, 1, 5'd10); d0r = 4'd9;
    d1i = mk(32'hB, 1, 32'hB, 1, 5'd11); d1r = 4'd10;
    step();
    chk("t5_cnt", 81'(cnt), 81'd6);
    chk("t5_num0", 81'(n0), 81'd4);

    // Flush and reset beat concurrent activity
    idle(); flush = 1; d0v = 1; d0i = rand_inst(); wb0v = 1; wb0r = 4'd1; is0 = 1;
    step();
    chk("t6_cnt", 81'(cnt), 81'd0);
    chk("t6_rs0", o0, 81'd0);
    idle(); d0v = 1; d0i = rand_inst(); d0r = 4'd1; step();
    idle(); rst = 1; d1v = 1; d1i = rand_inst(); wb1v = 1; step();
    chk("t6_rst_cnt", 81'(cnt), 81'd0);
    chk("t6_rst_rs1", o1, 81'd0);

    // Random traffic
    for (int c = 0; c < 600; c++) begin
      idle();
      rst   = ($urandom_range(0, 99) == 0);
      flush = ($urandom_range(0, 49) == 0);
      d0v = 1'($urandom_range(0, 1)); d0i = rand_inst(); d0r = 4'($urandom);
      d1v = 1'($urandom_range(0, 1)); d1i = rand_inst(); d1r = 4'($urandom);
      wb0v = 1'($urandom_range(0, 1)); wb0r = 4'($urandom_range(0, 8)); wb0d = $urandom;
      wb1v = 1'($urandom_range(0, 1)); wb1r = 4'($urandom_range(0, 8)); wb1d = $urandom;
      is0 = 1'($urandom_range(0, 1)); is1 = 1'($urandom_range(0, 1));
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
